twiddle_scheduler: RTL and testbench

TWIDDLE_SCHEDULER -- requirements
Module: twiddle_scheduler

---
 rtl/fft_ctrl_pkg.sv | 24 ++
 rtl/twiddle_index_gen.sv | 24 ++
 rtl/twiddle_scheduler.sv | 129 ++++++++++++
 tb/tb_twiddle_scheduler.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_ctrl_pkg.sv
// Shared constants and types for the FFT twiddle scheduling control path.
package fft_ctrl_pkg;

  localparam int LOG2N      = 6;
  localparam int NSTAGES    = 6;
  localparam int NBEATS     = 8;
  localparam int LANES      = 8;
  localparam int LANE_SHIFT = $clog2(LANES);
  localparam int OUTST_W    = 4;

  localparam logic [OUTST_W-1:0] OUTST_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/twiddle_index_gen.sv
// Combinational twiddle index for lane 0 and per-lane increment of one beat.
module twiddle_index_gen
  import fft_ctrl_pkg::*;
#(
  parameter int STAGE_W = 3,
  parameter int BEAT_W  = 3
) (
  input  logic [STAGE_W-1:0] i_stage,
  input  logic [BEAT_W-1:0]  i_beat,
  output logic [LOG2N-1:0]   o_start,
  output logic [LOG2N-1:0]   o_step
);

  logic [STAGE_W-1:0] w_shift;
  logic [LOG2N-1:0]   w_base;

  // Everything is mod 2^LOG2N, so truncating before the shift loses nothing.
  assign w_shift = STAGE_W'(LOG2N - 1) - i_stage;
  assign w_base  = LOG2N'(i_beat) << LANE_SHIFT;

  assign o_start = w_base << w_shift;
  assign o_step  = LOG2N'(1) << w_shift;

endmodule

// File: rtl/twiddle_scheduler.sv
// Sequences radix-2 stages of beats to the complex multiplier, tracking in-flight results.
module twiddle_scheduler #(
  parameter int NSTAGES = fft_ctrl_pkg::NSTAGES,
  parameter int NBEATS  = fft_ctrl_pkg::NBEATS
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           go,
  input  logic                           src_valid,
  output logic                           src_ready,
  output logic                           cm_isValid,
  output logic [fft_ctrl_pkg::LOG2N-1:0] cm_start,
  output logic [fft_ctrl_pkg::LOG2N-1:0] cm_step,
  input  logic                           cm_resultValid,
  output logic                           busy,
  output logic                           done,
  output logic                           err
);

  import fft_ctrl_pkg::*;

  localparam int STAGE_W = clog2_min1(NSTAGES);
  localparam int BEAT_W  = clog2_min1(NBEATS);

  state_t             r_state, w_state_nxt;
  logic [STAGE_W-1:0] r_stage, w_stage_nxt;
  logic [BEAT_W-1:0]  r_beat, w_beat_nxt;
  logic [OUTST_W-1:0] r_outst, w_outst_nxt;
  logic               r_err;

  logic               w_issue_req;
  logic               w_block;
  logic               w_issue;
  logic               w_res_spur;
  logic [LOG2N-1:0]   w_start;
  logic [LOG2N-1:0]   w_step;

  twiddle_index_gen #(
    .STAGE_W (STAGE_W),
    .BEAT_W  (BEAT_W)
  ) u_index_gen (
    .i_stage (r_stage),
    .i_beat  (r_beat),
    .o_start (w_start),
    .o_step  (w_step)
  );

  assign w_issue_req = rst_n && (r_state == ISSUE) && src_valid;
  assign w_block     = (r_outst == OUTST_MAX);
  assign w_issue     = w_issue_req && !w_block;
  assign w_res_spur  = cm_resultValid && (r_outst == '0);

  // A simultaneous issue and result cancel; a result with nothing in flight is dropped.
  always_comb begin
    w_outst_nxt = r_outst;
    if (w_issue && !cm_resultValid) begin
      w_outst_nxt = r_outst + OUTST_W'(1);
    end else if (!w_issue && cm_resultValid && (r_outst != '0)) begin
      w_outst_nxt = r_outst - OUTST_W'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_stage_nxt = r_stage;
    w_beat_nxt  = r_beat;
    case (r_state)
      IDLE: begin
        if (go) begin
          w_state_nxt = ISSUE;
          w_stage_nxt = '0;
          w_beat_nxt  = '0;
        end
      end
      ISSUE: begin
        if (w_issue) begin
          if (r_beat == BEAT_W'(NBEATS - 1)) begin
            w_state_nxt = DRAIN;
          end else begin
            w_beat_nxt = r_beat + BEAT_W'(1);
          end
        end
      end
      // Using the post-update count lets a result in this cycle release the stage.
      DRAIN: begin
        if (w_outst_nxt == '0) begin
          if (r_stage == STAGE_W'(NSTAGES - 1)) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = ISSUE;
            w_stage_nxt = r_stage + STAGE_W'(1);
            w_beat_nxt  = '0;
          end
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_stage <= '0;
      r_beat  <= '0;
      r_outst <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_stage <= w_stage_nxt;
      r_beat  <= w_beat_nxt;
      r_outst <= w_outst_nxt;
      r_err   <= r_err || w_res_spur || (w_issue_req && w_block);
    end
  end

  assign src_ready  = w_issue;
  assign cm_isValid = w_issue;
  assign cm_start   = rst_n ? w_start : '0;
  assign cm_step    = rst_n ? w_step : '0;
  assign busy       = rst_n && (r_state != IDLE);
  assign done       = rst_n && (r_state == DONE);
  assign err        = rst_n && r_err;

endmodule

// File: tb/tb_twiddle_scheduler.sv
// Scoreboard bench: runs push expected beats, a negedge monitor pops and compares on each issue.
module tb_twiddle_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       go;
  logic       src_valid;
  logic       src_ready;
  logic       cm_isValid;
  logic [5:0] cm_start;
  logic [5:0] cm_step;
  logic       cm_resultValid;
  logic       busy;
  logic       done;
  logic       err;

  always #5 clk = ~clk;

  twiddle_scheduler dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .go             (go),
    .src_valid      (src_valid),
    .src_ready      (src_ready),
    .cm_isValid     (cm_isValid),
    .cm_start       (cm_start),
    .cm_step        (cm_step),
    .cm_resultValid (cm_resultValid),
    .busy           (busy),
    .done           (done),
    .err            (err)
  );

  typedef struct {
    int stage;
    int beat;
    int start;
    int step;
  } exp_t;

  exp_t exp_q[$];

  int n_vec      = 0;
  int n_bad      = 0;
  int done_cnt   = 0;
  int run_issues = 0;
  int tb_outst   = 0;
  int lat        = 1;
  bit bp         = 1'b0;
  bit spur       = 1'b0;
  bit prev_done  = 1'b0;
  bit tog        = 1'b0;
  bit pipe [0:31];

  // Hand-computed index vectors: (stage, beat) -> (start, step)
  int hs  [3] = '{0, 3, 5};
  int hb  [3] = '{1, 5, 3};
  int hst [3] = '{0, 32, 24};
  int hsp [3] = '{32, 4, 1};

  task automatic chk(input string nm, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic push_run();
    exp_t e;
    exp_q.delete();
    for (int s = 0; s < 6; s++) begin
      for (int b = 0; b < 8; b++) begin
        e.stage = s;
        e.beat  = b;
        e.step  = 32 >> s;
        e.start = (b * 8 * (32 >> s)) % 64;
        exp_q.push_back(e);
      end
    end
  endtask

  // Upstream source and multiplier model: fixed-latency result per issued beat.
  initial begin
    bit iss;
    cm_resultValid = 1'b0;
    src_valid      = 1'b1;
    foreach (pipe[i]) pipe[i] = 1'b0;
    forever begin
      @(negedge clk);
      iss = cm_isValid;
      @(posedge clk);
      #2;
      for (int i = 31; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = iss;
      if (!rst_n) begin
        foreach (pipe[i]) pipe[i] = 1'b0;
      end
      tog            = ~tog;
      src_valid      = bp ? tog : 1'b1;
      cm_resultValid = pipe[lat-1] | spur;
    end
  end

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (cm_isValid) begin
          run_issues++;
          chk("src_valid_at_issue", int'(src_valid), 1);
          if (exp_q.size() == 0) begin
            chk("unexpected_issue", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("cm_start_s%0d_b%0d", e.stage, e.beat), int'(cm_start), e.start);
            chk($sformatf("cm_step_s%0d_b%0d", e.stage, e.beat), int'(cm_step), e.step);
            if (e.beat == 0 && e.stage > 0)
              chk($sformatf("outstanding_before_s%0d", e.stage), tb_outst, 0);
            for (int k = 0; k < 3; k++) begin
              if (e.stage == hs[k] && e.beat == hb[k]) begin
                chk($sformatf("hand_start_s%0d_b%0d", hs[k], hb[k]), int'(cm_start), hst[k]);
                chk($sformatf("hand_step_s%0d_b%0d", hs[k], hb[k]), int'(cm_step), hsp[k]);
              end
            end
          end
        end
        if (!src_valid || !busy) chk("no_issue_when_blocked", int'(cm_isValid), 0);
        chk("src_ready_eq_isvalid", int'(src_ready), int'(cm_isValid));
        if (done) begin
          done_cnt++;
          chk("busy_during_done", int'(busy), 1);
          chk("done_single_cycle", int'(prev_done), 0);
        end
        prev_done = done;
        if (cm_isValid) tb_outst++;
        if (cm_resultValid && tb_outst > 0) tb_outst--;
      end else begin
        tb_outst  = 0;
        prev_done = 1'b0;
      end
    end
  end

  task automatic run_full(input string nm, input int l, input bit b, input bit rego);
    int d0;
    int i0;
    int cyc;
    lat = l;
    bp  = b;
    push_run();
    d0 = done_cnt;
    i0 = run_issues;
    @(posedge clk); #1 go = 1'b1;
    @(posedge clk); #1 go = 1'b0;
    cyc = 0;
    while (done_cnt == d0 && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      go = (rego && cyc == 20);
    end
    go = 1'b0;
    if (cyc >= 2000) chk({nm, "_done_timeout"}, 0, 1);
    repeat (10) @(posedge clk);
    #1;
    chk({nm, "_issues"}, run_issues - i0, 48);
    chk({nm, "_done_pulses"}, done_cnt - d0, 1);
    chk({nm, "_busy_after"}, int'(busy), 0);
    chk({nm, "_err"}, int'(err), 0);
    chk({nm, "_queue_left"}, exp_q.size(), 0);
  endtask

  initial begin
    int d0;
    int i0;
    int i1;
    int cyc;
    rst_n = 1'b0;
    go    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_src_ready", int'(src_ready), 0);
    chk("rst_isvalid", int'(cm_isValid), 0);
    chk("rst_start", int'(cm_start), 0);
    chk("rst_step", int'(cm_step), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", int'(busy), 0);
    chk("idle_err", int'(err), 0);

    run_full("full", 1, 1'b0, 1'b1);
    run_full("backpressure", 1, 1'b1, 1'b0);
    run_full("drain_lat10", 10, 1'b0, 1'b0);

    // Spurious result while idle
    @(posedge clk); #1 spur = 1'b1;
    @(posedge clk); #1 spur = 1'b0;
    @(posedge clk); #1;
    chk("spur_err_set", int'(err), 1);
    chk("spur_busy", int'(busy), 0);
    repeat (5) @(posedge clk);
    #1;
    chk("spur_err_sticky", int'(err), 1);

    // Reset in the middle of stage 2
    lat = 1;
    bp  = 1'b0;
    push_run();
    d0 = done_cnt;
    i0 = run_issues;
    @(posedge clk); #1 go = 1'b1;
    @(posedge clk); #1 go = 1'b0;
    cyc = 0;
    while ((run_issues - i0) < 19 && cyc < 500) begin
      @(posedge clk);
      cyc++;
    end
    if (cyc >= 500) chk("midreset_reach_timeout", 0, 1);
    #1 rst_n = 1'b0;
    #2;
    chk("midreset_src_ready", int'(src_ready), 0);
    chk("midreset_isvalid", int'(cm_isValid), 0);
    chk("midreset_start", int'(cm_start), 0);
    chk("midreset_step", int'(cm_step), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    #1;
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_err", int'(err), 0);
    chk("midreset_done", int'(done), 0);
    i1 = run_issues;
    repeat (20) @(posedge clk);
    #1;
    chk("midreset_no_more_issues", run_issues - i1, 0);
    chk("midreset_no_done", done_cnt - d0, 0);
    chk("midreset_err_stays", int'(err), 0);
    chk("midreset_idle", int'(busy), 0);
    exp_q.delete();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
